controle_execucao: RTL and testbench

Run controller for the 8-bit NRISC single-cycle core and its instruction memory (MemInstrucao).
- Streams a program into instruction memory through a valid/ready byte interface.
- Loads the start PC into the core, then lets the core run.
- Watches the fetched instruction for the halt opcode, counts executed cycles and enforces a cycle-budget timeout.
- Sits between the host/bench and the processorNrisc/MemInstrucao pair.

---
 rtl/nrisc_pkg.sv | 16 +
 rtl/contador_ciclos.sv | 25 ++
 rtl/controle_execucao.sv | 114 +++++++++++
 tb/tb_controle_execucao.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared constants for the NRISC core, its memories and the run controller.
package nrisc_pkg;
  localparam int         NRISC_ADDR_W    = 8;
  localparam int         NRISC_DATA_W    = 8;
  localparam int         NRISC_CNT_W     = 16;
  localparam logic [7:0] HALT_OPCODE_DEF = 8'b1100_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4,
    ST_TOUT  = 3'd5
  } estado_t;
endpackage

// File: rtl/contador_ciclos.sv
// Saturating cycle counter with synchronous clear/enable and a terminal-count flag.
module contador_ciclos #(
  parameter int               CNT_W = 16,
  parameter logic [CNT_W-1:0] TERM  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);
  localparam logic [CNT_W-1:0] L_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_en && (r_cnt != '1))  r_cnt <= r_cnt + L_ONE;
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == TERM);
endmodule

// File: rtl/controle_execucao.sv
// Run controller: streams a program into instruction memory, primes the core PC,
// runs the core until the halt opcode or the cycle budget, and reports the outcome.
module controle_execucao
  import nrisc_pkg::*;
#(
  parameter int                ADDR_W      = NRISC_ADDR_W,
  parameter int                DATA_W      = NRISC_DATA_W,
  parameter int                CNT_W       = NRISC_CNT_W,
  parameter logic [DATA_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [CNT_W-1:0]  MAX_CICLOS  = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_inicial,
  input  logic [DATA_W-1:0] instr,
  output logic              mi_we,
  output logic [ADDR_W-1:0] mi_addr,
  output logic [DATA_W-1:0] mi_data,
  output logic              cpu_pc_load,
  output logic [ADDR_W-1:0] cpu_pc_val,
  output logic              cpu_run,
  output logic [CNT_W-1:0]  ciclos,
  output logic              busy,
  output logic              halted,
  output logic              timeout
);
  localparam logic [CNT_W-1:0] L_TERM = MAX_CICLOS - {{(CNT_W-1){1'b0}}, 1'b1};

  estado_t           r_state, w_next;
  logic              r_loaded;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_pc;
  logic              w_accept, w_pc_cap, w_term;

  assign load_ready = (r_state != ST_PRIME) && (r_state != ST_RUN);
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_loaded <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_pc     <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= w_accept;
      if (w_accept) begin
        r_addr   <= load_addr;
        r_data   <= load_data;
        r_loaded <= load_last;
      end
      if (w_pc_cap) r_pc <= pc_inicial;
    end
  end

  // A beat always beats start; a last beat from HALT/TOUT is a complete one-byte program.
  always_comb begin
    w_next   = r_state;
    w_pc_cap = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)                w_next = load_last ? ST_IDLE : ST_LOAD;
        else if (start && r_loaded) begin
          w_next   = ST_PRIME;
          w_pc_cap = 1'b1;
        end
      end
      ST_LOAD:  if (w_accept && load_last) w_next = ST_IDLE;
      ST_PRIME: w_next = ST_RUN;
      ST_RUN: begin
        if (instr == HALT_OPCODE) w_next = ST_HALT;
        else if (w_term)          w_next = ST_TOUT;
      end
      ST_HALT, ST_TOUT: begin
        if (w_accept)   w_next = load_last ? ST_IDLE : ST_LOAD;
        else if (start) begin
          w_next   = ST_PRIME;
          w_pc_cap = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  contador_ciclos #(.CNT_W(CNT_W), .TERM(L_TERM)) u_contador (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (r_state == ST_PRIME),
    .i_en   (r_state == ST_RUN),
    .o_cnt  (ciclos),
    .o_term (w_term)
  );

  assign mi_we       = r_we;
  assign mi_addr     = r_addr;
  assign mi_data     = r_data;
  assign cpu_pc_load = (r_state == ST_PRIME);
  assign cpu_pc_val  = r_pc;
  // Gated with reset so the core freezes the instant reset asserts.
  assign cpu_run     = (r_state == ST_RUN) && reset;
  assign busy        = (r_state == ST_PRIME) || (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);
  assign timeout     = (r_state == ST_TOUT);
endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao with a per-cycle reference model and literal spot checks.
module tb_controle_execucao;
  localparam int         MAXC = 8;
  localparam logic [7:0] HALT = 8'hC0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, start = 1'b0;
  logic [7:0]  load_addr = '0, load_data = '0, pc_inicial = '0, instr = '0;
  logic        load_ready, mi_we, cpu_pc_load, cpu_run, busy, halted, timeout;
  logic [7:0]  mi_addr, mi_data, cpu_pc_val;
  logic [15:0] ciclos;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  controle_execucao #(.MAX_CICLOS(16'd8)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
    .start(start), .pc_inicial(pc_inicial), .instr(instr),
    .mi_we(mi_we), .mi_addr(mi_addr), .mi_data(mi_data),
    .cpu_pc_load(cpu_pc_load), .cpu_pc_val(cpu_pc_val), .cpu_run(cpu_run),
    .ciclos(ciclos), .busy(busy), .halted(halted), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: tracks "has a complete program", "priming", "running" and the outcome.
  bit   m_ld = 0, m_prime = 0, m_run = 0, m_halt = 0, m_tout = 0, m_we = 0;
  int   m_cnt = 0;
  logic [7:0] m_addr = '0, m_data = '0, m_pc = '0;

  always @(posedge clock or negedge reset) begin
    bit acc;
    if (!reset) begin
      m_ld = 0; m_prime = 0; m_run = 0; m_halt = 0; m_tout = 0; m_we = 0;
      m_cnt = 0; m_addr = '0; m_data = '0; m_pc = '0;
    end else begin
      acc  = load_valid && !(m_prime || m_run);
      m_we = acc;
      if (acc) begin m_addr = load_addr; m_data = load_data; end
      if (m_prime) begin
        m_prime = 0; m_run = 1; m_cnt = 0;
      end else if (m_run) begin
        if (m_cnt < 65535) m_cnt++;
        if (instr == HALT)      begin m_run = 0; m_halt = 1; end
        else if (m_cnt == MAXC) begin m_run = 0; m_tout = 1; end
      end else if (acc) begin
        m_halt = 0; m_tout = 0; m_ld = load_last;
      end else if (start && m_ld) begin
        m_prime = 1; m_pc = pc_inicial; m_halt = 0; m_tout = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("load_ready",  load_ready,  !(m_prime || m_run));
    chk("mi_we",       mi_we,       m_we);
    chk("mi_addr",     mi_addr,     m_addr);
    chk("mi_data",     mi_data,     m_data);
    chk("cpu_pc_load", cpu_pc_load, m_prime);
    chk("cpu_pc_val",  cpu_pc_val,  m_pc);
    chk("cpu_run",     cpu_run,     m_run);
    chk("ciclos",      ciclos,      m_cnt);
    chk("busy",        busy,        m_prime || m_run);
    chk("halted",      halted,      m_halt);
    chk("timeout",     timeout,     m_tout);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    load_valid = 1; load_addr = a; load_data = d; load_last = last;
    tick(1);
    chk("beat_we", mi_we, 1);
    chk("beat_addr", mi_addr, a);
    chk("beat_data", mi_data, d);
  endtask

  initial begin
    #3;
    chk("rst_ready", load_ready, 1);
    chk("rst_run", cpu_run, 0);
    chk("rst_ciclos", ciclos, 0);
    chk("rst_we", mi_we, 0);
    #9 reset = 1;
    tick(1);

    // Program load, three back-to-back beats
    beat(8'd20, 8'hE0, 0);
    beat(8'd21, 8'h0F, 0);
    beat(8'd22, 8'hC0, 1);
    load_valid = 0; load_last = 0;
    tick(1);
    chk("load_done_we", mi_we, 0);
    chk("load_done_busy", busy, 0);

    // Run to halt
    pc_inicial = 8'd22; start = 1;
    tick(1);
    chk("prime_pcload", cpu_pc_load, 1);
    chk("prime_pcval", cpu_pc_val, 22);
    chk("prime_ready", load_ready, 0);
    start = 0; instr = HALT;
    tick(1);
    chk("run_cpu_run", cpu_run, 1);
    chk("run_ciclos0", ciclos, 0);
    tick(1);
    chk("halt_halted", halted, 1);
    chk("halt_ciclos", ciclos, 1);
    chk("halt_busy", busy, 0);
    chk("halt_run", cpu_run, 0);
    instr = 8'h00;

    // Timeout after the budget of 8 RUN cycles
    start = 1;
    tick(1);
    chk("rerun_halted_clr", halted, 0);
    start = 0;
    tick(9);
    chk("tout_timeout", timeout, 1);
    chk("tout_ciclos", ciclos, 8);
    chk("tout_run", cpu_run, 0);
    tick(2);
    chk("tout_frozen", ciclos, 8);

    // Halt in the last budget cycle: halt wins
    start = 1;
    tick(1);
    start = 0;
    tick(8);
    chk("budget_still_run", cpu_run, 1);
    chk("budget_ciclos7", ciclos, 7);
    instr = HALT;
    tick(1);
    chk("budget_halted", halted, 1);
    chk("budget_timeout", timeout, 0);
    chk("budget_ciclos", ciclos, 8);
    instr = 8'h00;

    // start + beat together after halt: beat wins
    start = 1; load_valid = 1; load_addr = 8'd5; load_data = 8'hAA; load_last = 0;
    tick(1);
    chk("both_halted_clr", halted, 0);
    chk("both_pcload", cpu_pc_load, 0);
    chk("both_we", mi_we, 1);
    load_valid = 0;
    tick(1);
    chk("load_start_ign", busy, 0);
    beat(8'd6, 8'h01, 1);
    load_valid = 0; load_last = 0; start = 0;

    // Reset in the middle of a run
    pc_inicial = 8'd6; start = 1;
    tick(1);
    start = 0;
    tick(6);
    chk("mid_ciclos5", ciclos, 5);
    chk("mid_running", cpu_run, 1);
    #2 reset = 0;
    #1;
    chk("rstrun_run", cpu_run, 0);
    chk("rstrun_ciclos", ciclos, 0);
    chk("rstrun_ready", load_ready, 1);
    #2 reset = 1;
    tick(1);

    // start with nothing loaded is ignored
    start = 1;
    tick(2);
    chk("noload_busy", busy, 0);
    chk("noload_pcload", cpu_pc_load, 0);
    start = 0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
